// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with stalled-redirect hold and return-address stack
module pc_unit #(
    parameter int WIDTH     = 32,
    parameter int PC_INIT   = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ihit,
    input  logic [2:0]                     pc_select,
    input  logic [WIDTH-1:0]               jump_data,
    output logic [WIDTH-1:0]               imemaddr,
    output logic [WIDTH-1:0]               rtn_addr,
    output logic                           halted,
    output logic                           redirect_pending,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_underflow
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [2:0] SEL_NEXT     = 3'd0;
    localparam logic [2:0] SEL_JUMP     = 3'd1;
    localparam logic [2:0] SEL_JUMPLINK = 3'd2;
    localparam logic [2:0] SEL_JUMPREG  = 3'd3;
    localparam logic [2:0] SEL_BRANCH   = 3'd4;
    localparam logic [2:0] SEL_RETURN   = 3'd5;
    localparam logic [2:0] SEL_HALT     = 3'd6;
    localparam logic [2:0] SEL_RSVD     = 3'd7;

    localparam logic [CW-1:0]    RAS_FULL = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]    PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [WIDTH-1:0] PC_RST   = WIDTH'(PC_INIT);
    localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);

    logic [WIDTH-1:0] pc;
    logic [2:0]       pend_sel;
    logic [WIDTH-1:0] pend_data;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;      // slot the next push writes

    logic [2:0]       eff_sel;
    logic [WIDTH-1:0] eff_data;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] br_offset;
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic             apply;
    logic             do_push;
    logic             do_pop;
    logic             live_redirect;

    assign imemaddr = pc;
    assign rtn_addr = pc + FOUR;

    assign apply         = ihit && !halted;
    assign eff_sel       = redirect_pending ? pend_sel  : pc_select;
    assign eff_data      = redirect_pending ? pend_data : jump_data;
    assign do_push       = apply && (eff_sel == SEL_JUMPLINK);
    assign do_pop        = apply && (eff_sel == SEL_RETURN) && (ras_count != '0);
    assign live_redirect = (pc_select != SEL_NEXT) && (pc_select != SEL_RSVD);

    assign br_offset = {{(WIDTH-18){eff_data[15]}}, eff_data[15:0], 2'b00};
    assign ptr_inc   = (ras_ptr == PTR_LAST) ? '0 : ras_ptr + 1'b1;
    assign ptr_dec   = (ras_ptr == '0) ? PTR_LAST : ras_ptr - 1'b1;

    // Next-PC selection for the effective request
    always_comb begin
        next_pc = pc + FOUR;
        case (eff_sel)
            SEL_JUMP, SEL_JUMPLINK: next_pc = {pc[WIDTH-1:28], eff_data[25:0], 2'b00};
            SEL_JUMPREG:            next_pc = eff_data;
            SEL_BRANCH:             next_pc = pc + FOUR + br_offset;
            SEL_RETURN:             next_pc = (ras_count != '0) ? ras_mem[ptr_dec] : eff_data;
            SEL_HALT:               next_pc = pc;
            default:                next_pc = pc + FOUR;
        endcase
    end

    // PC, halt flag, stalled-redirect capture and RAS bookkeeping
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc               <= PC_RST;
            halted           <= 1'b0;
            redirect_pending <= 1'b0;
            pend_sel         <= SEL_NEXT;
            pend_data        <= '0;
            ras_count        <= '0;
            ras_ptr          <= '0;
            ras_underflow    <= 1'b0;
        end else begin
            ras_underflow <= 1'b0;
            if (apply) begin
                pc               <= next_pc;
                redirect_pending <= 1'b0;
                if (eff_sel == SEL_HALT) begin
                    halted <= 1'b1;
                end
                if (do_push) begin
                    ras_ptr <= ptr_inc;
                    if (ras_count != RAS_FULL) begin
                        ras_count <= ras_count + 1'b1;
                    end
                end else if (do_pop) begin
                    ras_ptr   <= ptr_dec;
                    ras_count <= ras_count - 1'b1;
                end else if (eff_sel == SEL_RETURN) begin
                    ras_underflow <= 1'b1;
                end
            end else if (!halted && live_redirect) begin
                // latest non-sequential request during a stall wins
                pend_sel         <= pc_select;
                pend_data        <= jump_data;
                redirect_pending <= 1'b1;
            end
        end
    end

    // RAS storage; a full stack overwrites its oldest slot as the pointer wraps
    always_ff @(posedge CLK) begin
        if (!RST && do_push) begin
            ras_mem[ras_ptr] <= rtn_addr;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, JL = 3'd2, JR = 3'd3,
                           BR = 3'd4, RET = 3'd5, HALT = 3'd6, RSVD = 3'd7;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0;
    logic [2:0]  pc_select = 3'd0;
    logic [31:0] jump_data = 32'd0;
    logic [31:0] imemaddr;
    logic [31:0] rtn_addr;
    logic        halted;
    logic        redirect_pending;
    logic [2:0]  ras_count;
    logic        ras_underflow;

    int checks = 0;
    int failures = 0;

    pc_unit #(.WIDTH(32), .PC_INIT(0), .RAS_DEPTH(4)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ihit             (ihit),
        .pc_select        (pc_select),
        .jump_data        (jump_data),
        .imemaddr         (imemaddr),
        .rtn_addr         (rtn_addr),
        .halted           (halted),
        .redirect_pending (redirect_pending),
        .ras_count        (ras_count),
        .ras_underflow    (ras_underflow)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic h, input logic [2:0] s, input logic [31:0] d);
        ihit      = h;
        pc_select = s;
        jump_data = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        RST = 1'b1;
        step(0, NEXT, 0);
        check("rst_pc", imemaddr, 32'h0);
        check("rst_rtn", rtn_addr, 32'h4);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pending", {31'd0, redirect_pending}, 32'd0);
        check("rst_count", {29'd0, ras_count}, 32'd0);
        check("rst_uflow", {31'd0, ras_underflow}, 32'd0);
        RST = 1'b0;

        // sequential fetch
        step(1, NEXT, 0);  check("seq1", imemaddr, 32'h4);
        step(1, RSVD, 0);  check("seq2_rsvd", imemaddr, 32'h8);
        step(1, NEXT, 0);  check("seq3", imemaddr, 32'hC);
        check("seq3_rtn", rtn_addr, 32'h10);
        step(0, NEXT, 0);  check("stall_hold1", imemaddr, 32'hC);
        step(0, NEXT, 0);  check("stall_hold2", imemaddr, 32'hC);
        check("stall_no_pend", {31'd0, redirect_pending}, 32'd0);

        // jump, branch, jump-register, wrap
        step(1, JR, 32'h1000_0010);   check("jr_setup", imemaddr, 32'h1000_0010);
        step(1, JUMP, 32'h0000_0100); check("jump", imemaddr, 32'h1000_0400);
        step(1, JR, 32'h40);
        step(1, BR, 32'hFFFF);        check("branch_neg1", imemaddr, 32'h40);
        step(1, BR, 32'h0003);        check("branch_pos3", imemaddr, 32'h50);
        step(1, JR, 32'h1234);        check("jr", imemaddr, 32'h1234);
        step(1, JR, 32'hFFFF_FFFC);   check("rtn_wrap", rtn_addr, 32'h0);
        step(1, NEXT, 0);             check("pc_wrap", imemaddr, 32'h0);

        // stalled redirect, latest wins, NEXT leaves pending alone
        step(1, JR, 32'h100);
        step(0, BR, 32'h0004);        check("stall_br_pend", {31'd0, redirect_pending}, 32'd1);
        check("stall_br_pc", imemaddr, 32'h100);
        step(0, JR, 32'h800);         check("stall_jr_pc", imemaddr, 32'h100);
        step(0, NEXT, 0);             check("stall_next_pend", {31'd0, redirect_pending}, 32'd1);
        step(1, NEXT, 0);             check("redirect_pc", imemaddr, 32'h800);
        check("redirect_clr", {31'd0, redirect_pending}, 32'd0);

        // RAS: five links into a 4-deep stack
        step(1, JR, 32'h1000);
        step(1, JL, 32'h800);   check("jl1_pc", imemaddr, 32'h2000);
        check("jl1_cnt", {29'd0, ras_count}, 32'd1);
        step(1, JL, 32'hC00);   check("jl2_pc", imemaddr, 32'h3000);
        step(1, JL, 32'h1000);
        step(1, JL, 32'h1400);  check("jl4_cnt", {29'd0, ras_count}, 32'd4);
        step(1, JL, 32'h1800);  check("jl5_pc", imemaddr, 32'h6000);
        check("jl5_cnt", {29'd0, ras_count}, 32'd4);
        step(1, RET, 32'h0);    check("ret1", imemaddr, 32'h5004);
        check("ret1_cnt", {29'd0, ras_count}, 32'd3);
        step(1, RET, 32'h0);    check("ret2", imemaddr, 32'h4004);
        step(1, RET, 32'h0);    check("ret3", imemaddr, 32'h3004);
        step(1, RET, 32'h0);    check("ret4", imemaddr, 32'h2004);
        check("ret4_cnt", {29'd0, ras_count}, 32'd0);
        check("ret4_uflow", {31'd0, ras_underflow}, 32'd0);
        step(1, RET, 32'h900);  check("ret5_pc", imemaddr, 32'h900);
        check("ret5_uflow", {31'd0, ras_underflow}, 32'd1);
        check("ret5_cnt", {29'd0, ras_count}, 32'd0);
        step(1, NEXT, 0);       check("uflow_pulse_end", {31'd0, ras_underflow}, 32'd0);
        check("after_uflow_pc", imemaddr, 32'h904);

        // halt freezes everything until reset
        step(1, HALT, 0);       check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", imemaddr, 32'h904);
        for (int i = 0; i < 10; i++) begin
            step(1, JUMP, 32'h0000_0040 + 32'(i));
            check("halt_freeze", imemaddr, 32'h904);
        end
        check("halt_sticky", {31'd0, halted}, 32'd1);
        RST = 1'b1;
        step(1, JUMP, 32'h40);  check("halt_rst_pc", imemaddr, 32'h0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        RST = 1'b0;

        // reset in the middle of a stall
        step(1, JL, 32'h10);    check("mid_jl_pc", imemaddr, 32'h40);
        check("mid_jl_cnt", {29'd0, ras_count}, 32'd1);
        step(0, JUMP, 32'h200); check("mid_pend", {31'd0, redirect_pending}, 32'd1);
        RST = 1'b1;
        step(0, NEXT, 0);       check("mid_rst_pend", {31'd0, redirect_pending}, 32'd0);
        check("mid_rst_cnt", {29'd0, ras_count}, 32'd0);
        check("mid_rst_pc", imemaddr, 32'h0);
        RST = 1'b0;
        step(1, NEXT, 0);       check("mid_first_fetch", imemaddr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
